chebyshev_sequencer: RTL and testbench
======================================

Name: chebyshev_sequencer

Overview:
- Controller that evaluates one Chebyshev polynomial approximation per request, using the Clenshaw recurrence.
- Recurrence: b_k = 2x*b_{k+1} - b_{k+2} + c_k, for k = n down to 1; final y = x*b_1 - b_2 + c_0.
- Accepts (x, order) requests over a valid/ready handshake and issues coefficient-ROM reads.
- Drives clear/load/step/final strobes to the Chebyshev computation datapath, then returns the datapath result over a valid/ready handshake.

Parameters:
- WORD_LENGTH, 16, width of x and result.
- ORDER_MAX, 15, highest supported polynomial order.
- ADDR_WIDTH, 4, coefficient ROM address width; must satisfy 2^ADDR_WIDTH > ORDER_MAX.
- TIMEOUT_CYCLES, 64, maximum number of WAIT cycles before the request is aborted.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accept; high only in IDLE.
- in_x  input  WORD_LENGTH  evaluation point.
- in_order  input  8  requested order n.
- coeff_rd_en  output  1  ROM read strobe; ROM data reaches the datapath 1 cycle later.
- coeff_addr  output  ADDR_WIDTH  ROM address.
- dp_clear  output  1  clear b_{k+1} and b_{k+2} in the datapath.
- dp_x_load  output  1  load dp_x into the datapath.
- dp_x  output  WORD_LENGTH  latched x.
- dp_step  output  1  execute one recurrence step with the current ROM data.
- dp_final  output  1  execute the final step with the current ROM data (c_0).
- dp_done  input  1  datapath result ready; sampled only in WAIT.
- dp_result  input  WORD_LENGTH  datapath result.
- result_valid  output  1  result available.
- result_ready  input  1  consumer accept.
- result_data  output  WORD_LENGTH  captured result.
- result_err  output  1  timeout occurred.
- result_sat  output  1  in_order was clamped.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, CLEAR, STEP, FINAL, WAIT, DONE.
- Reset (sampled at a clock edge, honoured in any state, including mid-computation):
  - state goes to IDLE.
  - All outputs are 0 except in_ready = 1.
  - Internal x, order and counter registers are 0.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_x into the x register.
  - Latch n = min(in_order, ORDER_MAX); sat flag = (in_order > ORDER_MAX).
  - Next state CLEAR.
- CLEAR (1 cycle):
  - dp_clear = 1, dp_x_load = 1, coeff_rd_en = 1, coeff_addr = n; k <= n.
  - Next state is STEP if n >= 1, otherwise FINAL.
- STEP (n cycles):
  - dp_step = 1; the ROM data presented in this cycle is c_k.
  - If k > 1: coeff_rd_en = 1, coeff_addr = k-1, k <= k-1, stay in STEP.
  - If k == 1: coeff_rd_en = 1, coeff_addr = 0, next state FINAL.
- FINAL (1 cycle):
  - dp_final = 1; the ROM data presented is c_0.
  - Clear the timeout counter; next state WAIT.
- WAIT:
  - If dp_done = 1: capture dp_result into result_data, err = 0, next state DONE.
  - Otherwise increment the timeout counter.
  - When the counter reaches TIMEOUT_CYCLES-1 with dp_done low: result_data = 0, err = 1, next state DONE.
  - If dp_done and the timeout coincide in the same cycle, dp_done wins.
- DONE:
  - result_valid = 1; result_data, result_err and result_sat are held stable.
  - On result_ready: next state IDLE.
  - The next request can therefore be accepted no earlier than the cycle after the handshake.
  - result_data, result_err and result_sat keep their values until the next capture.
- Strobe timing:
  - dp_* strobes are single-cycle and mutually exclusive, except dp_clear/dp_x_load, which are asserted together.
  - dp_x is driven from the x register in every state.
- Ignored inputs:
  - dp_done outside WAIT is ignored.
  - in_valid outside IDLE is ignored (in_ready = 0).
- Latency: accept to first result_valid = n + 3 + D cycles, where D is the number of WAIT cycles before dp_done is sampled high (D >= 1).
- All control outputs are decoded from registered state; there are no combinational paths from inputs to outputs other than in_ready, which is decoded from state only.

Test Plan:
- Reset, then in_x = 0x4000, in_order = 3, accepted at edge 0; bench datapath raises dp_done in cycle 6 -> CLEAR in cycle 1 (addr 3); dp_step in cycles 2-4 with addrs 2, 1, 0; dp_final in cycle 5; result_valid from cycle 7 with result_data = dp_result, err = 0, sat = 0.
- in_order = 0 -> CLEAR (addr 0) in cycle 1, dp_final in cycle 2, no dp_step pulses.
- in_order = 40 -> 15 dp_step pulses with addrs 14..0, result_sat = 1.
- dp_done never asserted -> after exactly 64 WAIT cycles, result_valid = 1, result_err = 1, result_data = 0.
- result_ready held low for 10 cycles -> result_valid and data stable; in_ready stays 0; in_valid pulses are ignored.
- reset asserted during STEP (order 7, k = 4) -> next cycle IDLE, all strobes 0, in_ready = 1; a fresh order-2 request then completes normally.

Source files
------------

// File: rtl/chebyshev_sequencer.sv
// chebyshev_sequencer: Clenshaw-recurrence controller issuing ROM reads and datapath strobes per request
module chebyshev_sequencer #(
    parameter int WORD_LENGTH    = 16,
    parameter int ORDER_MAX      = 15,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_LENGTH-1:0] in_x,
    input  logic [7:0]             in_order,
    output logic                   coeff_rd_en,
    output logic [ADDR_WIDTH-1:0]  coeff_addr,
    output logic                   dp_clear,
    output logic                   dp_x_load,
    output logic [WORD_LENGTH-1:0] dp_x,
    output logic                   dp_step,
    output logic                   dp_final,
    input  logic                   dp_done,
    input  logic [WORD_LENGTH-1:0] dp_result,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [WORD_LENGTH-1:0] result_data,
    output logic                   result_err,
    output logic                   result_sat,
    output logic                   busy
);
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STEP, S_FINAL, S_WAIT, S_DONE} state_t;
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] OMAX_IN = 8'(ORDER_MAX);
    localparam logic [ADDR_WIDTH-1:0] OMAX = ADDR_WIDTH'(ORDER_MAX);
    state_t                 state_q, state_d;
    logic [WORD_LENGTH-1:0] x_q, x_d, data_q, data_d;
    logic [ADDR_WIDTH-1:0]  n_q, n_d, k_q, k_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   sat_in_q, sat_in_d, sat_q, sat_d, err_q, err_d;
    assign dp_x        = x_q;
    assign result_data = data_q;
    assign result_err  = err_q;
    assign result_sat  = sat_q;
    // State and datapath registers; reset clears everything including the held result
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            sat_in_q <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            n_q      <= n_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            sat_in_q <= sat_in_d;
            data_q   <= data_d;
            err_q    <= err_d;
            sat_q    <= sat_d;
        end
    end
    // Next-state logic and strobe decode, all outputs derived from registered state
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        n_d          = n_q;
        k_d          = k_q;
        cnt_d        = cnt_q;
        sat_in_d     = sat_in_q;
        data_d       = data_q;
        err_d        = err_q;
        sat_d        = sat_q;
        coeff_rd_en  = 1'b0;
        coeff_addr   = '0;
        dp_clear     = 1'b0;
        dp_x_load    = 1'b0;
        dp_step      = 1'b0;
        dp_final     = 1'b0;
        in_ready     = (state_q == S_IDLE);
        result_valid = (state_q == S_DONE);
        busy         = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d      = in_x;
                    sat_in_d = in_order > OMAX_IN;
                    n_d      = (in_order > OMAX_IN) ? OMAX : ADDR_WIDTH'(in_order);
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                dp_clear    = 1'b1;
                dp_x_load   = 1'b1;
                coeff_rd_en = 1'b1;
                coeff_addr  = n_q;
                k_d         = n_q;
                state_d     = (n_q != '0) ? S_STEP : S_FINAL;
            end
            S_STEP: begin
                dp_step     = 1'b1;
                coeff_rd_en = 1'b1;
                coeff_addr  = k_q - ADDR_WIDTH'(1);
                k_d         = (k_q > ADDR_WIDTH'(1)) ? k_q - ADDR_WIDTH'(1) : k_q;
                state_d     = (k_q > ADDR_WIDTH'(1)) ? S_STEP : S_FINAL;
            end
            S_FINAL: begin
                dp_final = 1'b1;
                cnt_d    = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (dp_done || cnt_q == CNT_LAST) begin
                    data_d  = dp_done ? dp_result : '0;
                    err_d   = !dp_done;
                    sat_d   = sat_in_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: state_d = result_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_chebyshev_sequencer.sv
// tb_chebyshev_sequencer: directed checks of sequencing, timeout, hold and reset behaviour
module tb_chebyshev_sequencer;
    logic        clock = 1'b0, reset = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] in_x = '0;
    logic [7:0]  in_order = '0;
    logic        coeff_rd_en, dp_clear, dp_x_load, dp_step, dp_final;
    logic [3:0]  coeff_addr;
    logic [15:0] dp_x, result_data;
    logic        dp_done = 1'b0;
    logic [15:0] dp_result = '0;
    logic        result_valid, result_ready = 1'b0, result_err, result_sat, busy;
    logic [4:0]  stb;
    int          tests = 0, fails = 0;

    chebyshev_sequencer dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_order(in_order), .coeff_rd_en(coeff_rd_en), .coeff_addr(coeff_addr),
        .dp_clear(dp_clear), .dp_x_load(dp_x_load), .dp_x(dp_x), .dp_step(dp_step),
        .dp_final(dp_final), .dp_done(dp_done), .dp_result(dp_result),
        .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
        .result_err(result_err), .result_sat(result_sat), .busy(busy)
    );

    assign stb = {dp_clear, dp_x_load, coeff_rd_en, dp_step, dp_final};
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // d = number of WAIT cycles up to and including the one with dp_done high; d = 0 means never
    task automatic run_req(input logic [15:0] x, input logic [7:0] order, input int d, input logic [15:0] res);
        int n;
        n = (order > 15) ? 15 : order;
        @(negedge clock);
        in_valid = 1'b1; in_x = x; in_order = order;
        check("accept_ready", in_ready, 1);
        @(negedge clock);
        in_valid = 1'b0;
        check("clear_stb", stb, 5'b11100);
        check("clear_addr", coeff_addr, n);
        check("clear_dpx", dp_x, x);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clock);
            check("step_stb", stb, 5'b00110);
            check("step_addr", coeff_addr, i);
        end
        @(negedge clock);
        check("final_stb", stb, 5'b00001);
        for (int j = 1; j <= ((d == 0) ? 64 : d); j++) begin
            @(negedge clock);
            check("wait_stb", stb, 0);
            check("wait_valid", result_valid, 0);
            if (j == d) begin dp_done = 1'b1; dp_result = res; end
        end
        @(negedge clock);
        dp_done = 1'b0;
        check("done_valid", result_valid, 1);
        check("done_data", result_data, (d == 0) ? 16'h0 : res);
        check("done_err", result_err, (d == 0) ? 1 : 0);
        check("done_sat", result_sat, (order > 15) ? 1 : 0);
        check("done_ready", in_ready, 0);
    endtask

    task automatic finish_req();
        result_ready = 1'b1;
        @(negedge clock);
        result_ready = 1'b0;
        check("idle_ready", in_ready, 1);
        check("idle_valid", result_valid, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_ready", in_ready, 1);
        check("rst_stb", stb, 0);
        check("rst_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", result_data, 0);
        check("rst_dpx", dp_x, 0);
        reset = 1'b0;
        run_req(16'h4000, 8'd3, 1, 16'h1234);
        finish_req();
        run_req(16'h1111, 8'd0, 1, 16'h0007);
        finish_req();
        run_req(16'h2222, 8'd40, 3, 16'hBEEF);
        finish_req();
        run_req(16'h3333, 8'd2, 0, 16'hFFFF);
        finish_req();
        run_req(16'hABCD, 8'd1, 2, 16'h5A5A);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; in_x = 16'hFFFF; in_order = 8'd5;
            dp_done = 1'b1; dp_result = 16'h0BAD;
            @(negedge clock);
            check("hold_valid", result_valid, 1);
            check("hold_data", result_data, 16'h5A5A);
            check("hold_err", result_err, 0);
            check("hold_ready", in_ready, 0);
            check("hold_dpx", dp_x, 16'hABCD);
        end
        in_valid = 1'b0; dp_done = 1'b0;
        finish_req();
        @(negedge clock);
        in_valid = 1'b1; in_x = 16'h7777; in_order = 8'd7;
        @(negedge clock);
        in_valid = 1'b0;
        check("r7_clear_addr", coeff_addr, 7);
        for (int i = 6; i >= 3; i--) begin
            @(negedge clock);
            check("r7_step_addr", coeff_addr, i);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_stb", stb, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", result_valid, 0);
        check("mid_rst_dpx", dp_x, 0);
        check("mid_rst_data", result_data, 0);
        run_req(16'h0100, 8'd2, 4, 16'hC0DE);
        finish_req();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
